// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one N-bit bus among 2**S requesters, with valid/ready output.
// Optional grant timeout with revocation enabled by defining RR_BUS_ARBITER_TIMEOUT_EN.

module mux #(
  parameter int unsigned N = 4,
  parameter int unsigned S = 2
) (
  input  logic [(2**S)-1:0][N-1:0] buses,
  input  logic [S-1:0]             select,
  output logic [N-1:0]             result
);
  assign result = buses[select];
endmodule

module rr_bus_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned S       = 2,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [(2**S)-1:0]        req,
  input  logic [(2**S)-1:0][N-1:0] buses,
  output logic [(2**S)-1:0]        grant,
  output logic [S-1:0]             select,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             result,
  output logic                     err_timeout
);
  localparam int unsigned R = 2**S;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [S-1:0]   ptr_q, ptr_d;
  logic [S-1:0]   select_q, select_d;
  logic [R-1:0]   grant_q, grant_d;
  logic           err_q, err_d;
  logic           accept, holding, timeout_hit;
  logic [S-1:0]   arb_ptr, win, idx;
  logic           win_found;
  logic [N-1:0]   mux_out;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  assign accept  = (state_q == StGrant) && out_ready;
  // Grantee still requesting and not accepted: candidate for waiting/timeout.
  assign holding = (state_q == StGrant) && !out_ready && req[select_q];

`ifdef RR_BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_hit = holding && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (holding && !timeout_hit) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign arb_ptr = (accept || timeout_hit) ? select_q + S'(1) : ptr_q;

  // First requester at or after arb_ptr, wrapping around.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < R; k++) begin
      idx = arb_ptr + S'(k);
      if (!win_found && req[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    select_d = select_q;
    grant_d  = grant_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          select_d = win;
          grant_d  = R'(1) << win;
          state_d  = StGrant;
        end
      end
      StGrant: begin
        if (accept || timeout_hit) begin
          ptr_d = arb_ptr;
          err_d = timeout_hit;
          if (win_found) begin
            select_d = win;
            grant_d  = R'(1) << win;
          end else begin
            grant_d = '0;
            state_d = StIdle;
          end
        end else if (!req[select_q]) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      select_q <= '0;
      grant_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      select_q <= select_d;
      grant_q  <= grant_d;
      err_q    <= err_d;
    end
  end

  mux #(
    .N(N),
    .S(S)
  ) u_mux (
    .buses  (buses),
    .select (select_q),
    .result (mux_out)
  );

  assign grant       = grant_q;
  assign select      = select_q;
  assign out_valid   = (state_q == StGrant);
  assign result      = out_valid ? mux_out : '0;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench for rr_bus_arbiter (N=4, S=2, TIMEOUT=3); a behavioural model queues expectations.
module tb_rr_bus_arbiter;
  localparam int unsigned TOUT = 3;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] select;
    logic       valid;
    logic [3:0] result;
    logic       err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req = '0;
  logic [3:0][3:0] buses;
  logic [3:0]      grant;
  logic [1:0]      select;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [3:0]      result;
  logic            err_timeout;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // Model state
  bit m_valid = 0;
  int m_ptr = 0, m_sel = 0, m_cnt = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter #(
    .N       (4),
    .S       (2),
    .TIMEOUT (TOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .buses       (buses),
    .grant       (grant),
    .select      (select),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .err_timeout (err_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs, predict the post-edge outputs, then compare.
  task automatic step(input logic [3:0] r, input logic rdy, input logic rs);
    exp_t e;
    exp_t got;
    int   w;
    bit   to;
    bit   err;
    req       = r;
    out_ready = rdy;
    rst       = rs;
    err       = 0;
    if (rs) begin
      m_valid = 0; m_ptr = 0; m_sel = 0; m_cnt = 0;
    end else if (!m_valid) begin
      w = pick(m_ptr, r);
      if (w >= 0) begin
        m_valid = 1; m_sel = w; m_cnt = 0;
      end
    end else begin
      to = 0;
`ifdef RR_BUS_ARBITER_TIMEOUT_EN
      to = !rdy && r[m_sel] && (m_cnt + 1 == TOUT);
`endif
      if (rdy || to) begin
        m_ptr = (m_sel + 1) % 4;
        err   = to;
        w     = pick(m_ptr, r);
        if (w >= 0) begin
          m_sel = w; m_cnt = 0;
        end else begin
          m_valid = 0;
        end
      end else if (!r[m_sel]) begin
        m_valid = 0;
      end else begin
        m_cnt++;
      end
    end
    e.valid  = m_valid;
    e.grant  = m_valid ? 4'(1 << m_sel) : 4'b0;
    e.select = 2'(m_sel);
    e.result = m_valid ? buses[m_sel] : 4'b0;
    e.err    = err;
    sb.push_back(e);

    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_eq("grant",       32'(grant),       32'(got.grant));
    check_eq("select",      32'(select),      32'(got.select));
    check_eq("out_valid",   32'(out_valid),   32'(got.valid));
    check_eq("result",      32'(result),      32'(got.result));
    check_eq("err_timeout", 32'(err_timeout), 32'(got.err));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) buses[i] = 4'(i);

    // Reset
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    check_eq("reset_valid", 32'(out_valid), 32'd0);

    // Single requester, accepted, then idle with ptr = 3
    step(4'b0100, 1'b0, 1'b0);
    check_eq("single_sel", 32'(select), 32'd2);
    check_eq("single_res", 32'(result), 32'd2);
    step(4'b0000, 1'b1, 1'b0);

    // Wrap and skip from ptr = 3
    step(4'b0011, 1'b0, 1'b0);
    check_eq("wrap_sel0", 32'(select), 32'd0);
    step(4'b0011, 1'b1, 1'b0);
    check_eq("wrap_sel1", 32'(select), 32'd1);
    step(4'b0000, 1'b1, 1'b0);

    // Backpressure then acceptance
    for (int i = 0; i < 6; i++) step(4'b0010, 1'b0, 1'b0);
    check_eq("bp_grant", 32'(grant), 32'b0010);
    step(4'b0000, 1'b1, 1'b0);

    // Withdrawal keeps ptr (=2): next arbitration of 0110 picks 2
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check_eq("withdraw_valid", 32'(out_valid), 32'd0);
    step(4'b0110, 1'b0, 1'b0);
    check_eq("after_wd_sel", 32'(select), 32'd2);

    // Reset mid-grant
    step(4'b0110, 1'b0, 1'b1);

    // All requesting, continuous acceptance
    for (int i = 0; i < 7; i++) step(4'b1111, 1'b1, 1'b0);

    // Timeout / hold behaviour
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(4'b0101, 1'b0, 1'b0);

    // Random traffic with varied bus data
    for (int i = 0; i < 4; i++) buses[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 60; i++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one N-bit output bus among 2**S requesters.
- Instantiates the team's existing `mux` (same N/S parameters, same packed `buses` layout) and drives its `select`.
- Presents the selected bus downstream with a valid/ready handshake.
- Sits between request-producing units and a single shared consumer.

Parameters:
- N, 4, data width of each bus and of result.
- S, 2, select width; number of requesters = 2**S.
- TIMEOUT, 8, cycles a grant may wait on out_ready before revocation; used only with the optional feature; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  2**S  per-requester request; bit i belongs to buses[i].
- buses  input  [(2**S)-1:0][N-1:0]  packed requester data, passed straight to the mux.
- grant  output  2**S  one-hot registered grant; all zeros when idle.
- select  output  S  registered index of the current grantee; drives mux select.
- out_valid  output  1  registered; high while a grant is outstanding.
- out_ready  input  1  downstream accepts the current beat.
- result  output  N  buses[select] when out_valid = 1, else 0.
- err_timeout  output  1  one-cycle pulse on grant revocation; tied 0 without the optional feature.

Behaviour:
- Reset, sampled at a clk edge with rst = 1:
  - state = IDLE; ptr = 0; grant = 0; select = 0; out_valid = 0; err_timeout = 0.
  - result = 0.
  - rst has priority over every other event, including mid-grant; any in-flight beat is dropped with no acceptance.
- State IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick winner w = first index with req[w] = 1, searching ptr, ptr+1, ... 2**S-1, 0, ... (wrapping).
  - At that edge: select <= w; grant <= one-hot(w); out_valid <= 1; state <= GRANT.
  - Latency: req asserted before edge k gives grant/out_valid high after edge k (one cycle).
- State GRANT:
  - Acceptance = out_valid && out_ready at an edge.
  - On acceptance: ptr <= (select + 1) mod 2**S, wrapping from 2**S-1 to 0.
  - Then re-arbitrate in the same edge using the new ptr and the current req, with the grantee's own bit included.
  - If any req is set: new select/grant, stay in GRANT, out_valid stays 1. Back-to-back beats, no bubble.
  - If no req is set: grant <= 0, out_valid <= 0, state <= IDLE.
- Requester protocol:
  - Requester i holds req[i] until it sees grant[i] && out_ready at an edge.
  - To send another beat, it keeps req[i] high.
- Withdrawal: req[select] low at an edge while in GRANT with no acceptance:
  - Grant is revoked: grant <= 0, out_valid <= 0, state <= IDLE, ptr unchanged.
  - err_timeout is not pulsed.
  - If acceptance and withdrawal coincide, acceptance wins.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,2**S-1,0,... One beat per grant, so no requester waits more than 2**S-1 accepted beats.
- Invariants:
  - grant is zero or one-hot; grant[select] = 1 whenever out_valid = 1.
  - out_valid = (state == GRANT).

Optional Feature:
- Macro: RR_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on every new grant and increments each GRANT cycle without acceptance.
  - When the count reaches TIMEOUT with no acceptance at that edge: grant revoked, ptr <= (select + 1) mod 2**S, and immediate re-arbitration follows the acceptance rules.
  - err_timeout pulses high for exactly one cycle following that edge.
  - Acceptance on the TIMEOUT edge wins; no pulse.
  - Reset clears the counter.
- Undefined: no counter; grant held until acceptance or withdrawal; err_timeout constant 0.

Test Plan:
- Reset, then single requester, N=4, S=2, buses = {3,2,1,0}: rst high 2 cycles -> all outputs 0. req = 4'b0100 -> one edge later grant = 0100, select = 2, out_valid = 1, result = 2. out_ready = 1 for one edge, req dropped -> IDLE, grant = 0, ptr = 3.
- All requesting: req = 4'b1111, out_ready = 1 continuously, from reset -> select sequence 0,1,2,3,0,1 on consecutive cycles; result matches select; out_valid never drops.
- Wrap and skip: ptr = 3 (after serving 2), req = 4'b0011 -> select = 0, then 1, then IDLE once req clears.
- Backpressure: req = 4'b0010, out_ready = 0 for 5 cycles -> grant stable at 0010, result = 1; then out_ready = 1 -> accepted; ptr = 2.
- Withdrawal and reset mid-grant:
  - req[1] dropped while granted, out_ready = 0 -> IDLE next cycle, ptr unchanged, err_timeout = 0.
  - rst asserted while in GRANT -> all outputs 0 next cycle.
- With RR_BUS_ARBITER_TIMEOUT_EN, TIMEOUT = 3: req = 4'b0101, out_ready = 0 -> select 0 held 3 cycles, then err_timeout pulses 1 cycle and select = 2. Without the macro: select 0 held indefinitely; err_timeout stays 0.
